brain_cmd_tx: RTL and testbench

Command-stream transmitter for the synth's parameter bus. Accepts one parameter update at a time (oscillator, parameter, value) over a valid/ready handshake. Serialises it into the byte protocol consumed by `brain`: command byte, little-endian data bytes, then terminator 0xFF. Each byte is presented on `o_data` with an `o_data_load` strobe held for a fixed number of clocks, followed by a fixed idle gap. It sits between the control front end and `brain`, driving `i_data`/`i_data_load` directly.

---
 rtl/brain_cmd_tx_if.sv | 38 +++
 rtl/brain_cmd_tx.sv | 130 +++++++++++++
 tb/tb_brain_cmd_tx.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/brain_cmd_tx_if.sv
// Handshake and byte-bus bundle between the control front end, brain_cmd_tx and brain.
interface brain_cmd_tx_if;
    logic        i_valid;
    logic        o_ready;
    logic        i_osc_sel;
    logic [1:0]  i_param;
    logic [23:0] i_value;
    logic [7:0]  o_data;
    logic        o_data_load;
    logic        o_busy;
    logic        o_done;

    // Requester side: issues updates and watches the byte stream.
    modport master (
        output i_valid,
        output i_osc_sel,
        output i_param,
        output i_value,
        input  o_ready,
        input  o_data,
        input  o_data_load,
        input  o_busy,
        input  o_done
    );

    // Transmitter side.
    modport slave (
        input  i_valid,
        input  i_osc_sel,
        input  i_param,
        input  i_value,
        output o_ready,
        output o_data,
        output o_data_load,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/brain_cmd_tx.sv
// Serialises one parameter update into the brain byte protocol:
// command byte, little-endian data bytes, then 0xFF, each byte strobed
// for LOAD_CYCLES clocks followed by a GAP_CYCLES idle gap.
module brain_cmd_tx #(
    parameter int unsigned LOAD_CYCLES = 5,
    parameter int unsigned GAP_CYCLES  = 5
) (
    input logic           i_clk,
    input logic           i_rst,
    brain_cmd_tx_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StLoad, StGap} state_e;

    localparam logic [7:0] LoadLast = 8'(LOAD_CYCLES - 1);
    localparam logic [7:0] GapLast  = 8'(GAP_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic [1:0]  param_q, param_d;
    logic [23:0] value_q, value_d;

    logic [7:0]  cmd_in;
    logic [2:0]  last_idx;
    logic [2:0]  nxt_idx;
    logic [7:0]  nxt_byte;

    // Command byte built straight from the inputs so it is ready on the accept edge.
    assign cmd_in  = {3'b000, bus.i_osc_sel, 4'(bus.i_param) + 4'd1};
    assign nxt_idx = idx_q + 3'd1;

    // Index of the terminator byte: data byte count plus one.
    always_comb begin
        unique case (param_q)
            2'd0:    last_idx = 3'd2;
            2'd1:    last_idx = 3'd4;
            default: last_idx = 3'd3;
        endcase
    end

    // Byte sent at the following index: data bytes LSB first, then the terminator.
    always_comb begin
        nxt_byte = 8'hFF;
        if (nxt_idx != last_idx) begin
            unique case (nxt_idx)
                3'd1:    nxt_byte = value_q[7:0];
                3'd2:    nxt_byte = value_q[15:8];
                default: nxt_byte = value_q[23:16];
            endcase
        end
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        done_d  = 1'b0;
        param_d = param_q;
        value_d = value_q;
        case (state_q)
            StIdle: begin
                if (bus.i_valid) begin
                    state_d = StLoad;
                    cnt_d   = 8'd0;
                    idx_d   = 3'd0;
                    param_d = bus.i_param;
                    value_d = bus.i_value;
                    data_d  = cmd_in;
                end
            end
            StLoad: begin
                if (cnt_q == LoadLast) begin
                    state_d = StGap;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d = 8'd0;
                    if (idx_q == last_idx) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StLoad;
                        idx_d   = nxt_idx;
                        data_d  = nxt_byte;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset abandons any partial frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            data_q  <= 8'd0;
            done_q  <= 1'b0;
            param_q <= 2'd0;
            value_q <= 24'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            done_q  <= done_d;
            param_q <= param_d;
            value_q <= value_d;
        end
    end

    assign bus.o_data      = data_q;
    assign bus.o_data_load = (state_q == StLoad);
    assign bus.o_busy      = (state_q != StIdle);
    assign bus.o_ready     = (state_q == StIdle) && !i_rst;
    assign bus.o_done      = done_q;

endmodule

// File: tb/tb_brain_cmd_tx.sv
// Self-checking bench for brain_cmd_tx: a frame-timeline model checked every
// cycle, plus hand-computed byte sequences and timing points.
module tb_brain_cmd_tx;
    localparam int L = 5;
    localparam int G = 5;
    localparam int P = L + G;

    logic clk = 1'b0;
    logic rst = 1'b0;

    brain_cmd_tx_if bus ();

    brain_cmd_tx #(
        .LOAD_CYCLES(L),
        .GAP_CYCLES (G)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model state: frame bytes and cycles elapsed since the accept edge.
    bit         m_active = 1'b0;
    int         m_t      = 0;
    int         m_n      = 3;
    logic [7:0] m_bytes[5];
    logic [7:0] m_data   = 8'h00;
    bit         m_done   = 1'b0;

    logic [7:0] cap_bytes[$];
    int         cap_cyc[$];
    int         done_cyc[$];
    bit         prev_load = 1'b0;

    function automatic int frame_len(input logic [1:0] prm);
        case (prm)
            2'd0:    return 3;
            2'd1:    return 5;
            default: return 4;
        endcase
    endfunction

    function automatic logic [7:0] frame_byte(input logic osc, input logic [1:0] prm,
                                              input logic [23:0] val, input int i);
        int n;
        n = frame_len(prm);
        if (i == 0) return 8'(16 * int'(osc) + int'(prm) + 1);
        if (i == n - 1) return 8'hFF;
        return 8'(val >> (8 * (i - 1)));
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Timeline model advanced on each active edge or reset.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_active = 1'b0;
                m_t      = 0;
                m_data   = 8'h00;
                m_done   = 1'b0;
            end else if (m_active) begin
                m_t++;
                m_done = 1'b0;
                if (m_t == m_n * P) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end else if (m_t % P == 0) begin
                    m_data = m_bytes[m_t / P];
                end
            end else begin
                m_done = 1'b0;
                if (bus.i_valid) begin
                    m_n = frame_len(bus.i_param);
                    for (int i = 0; i < 5; i++)
                        m_bytes[i] = frame_byte(bus.i_osc_sel, bus.i_param, bus.i_value, i);
                    m_active = 1'b1;
                    m_t      = 0;
                    m_data   = m_bytes[0];
                end
            end
        end
    end

    // Per-cycle compare against the model, plus byte and done capture.
    initial begin
        logic exp_load;
        logic exp_ready;
        forever begin
            @(negedge clk);
            cyc++;
            exp_load  = m_active && ((m_t % P) < L);
            exp_ready = !m_active && !rst;
            n_tests++;
            if (bus.o_data !== m_data || bus.o_data_load !== exp_load ||
                bus.o_busy !== m_active || bus.o_done !== m_done || bus.o_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL cycle %0d outputs: data=%h load=%b busy=%b done=%b ready=%b, expected data=%h load=%b busy=%b done=%b ready=%b",
                         cyc, bus.o_data, bus.o_data_load, bus.o_busy, bus.o_done, bus.o_ready,
                         m_data, exp_load, m_active, m_done, exp_ready);
            end
            if (bus.o_data_load && !prev_load) begin
                cap_bytes.push_back(bus.o_data);
                cap_cyc.push_back(cyc);
            end
            prev_load = bus.o_data_load;
            if (bus.o_done) done_cyc.push_back(cyc);
        end
    end

    task automatic start(input logic osc, input logic [1:0] prm, input logic [23:0] val,
                         output int acc);
        @(posedge clk);
        #2;
        bus.i_osc_sel = osc;
        bus.i_param   = prm;
        bus.i_value   = val;
        bus.i_valid   = 1'b1;
        @(posedge clk);
        #2;
        acc = cyc;
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_done(input int nd);
        for (int i = 0; i < 400; i++) begin
            if (done_cyc.size() >= nd) break;
            @(negedge clk);
            #1;
        end
        cmp("done_timeout", done_cyc.size() >= nd, 1);
    endtask

    task automatic check_bytes(input string name, input logic [7:0] e[8], input int n);
        cmp({name, "_count"}, cap_bytes.size(), n);
        for (int i = 0; i < n && i < cap_bytes.size(); i++)
            cmp($sformatf("%s_byte%0d", name, i), cap_bytes[i], e[i]);
    endtask

    task automatic check_reset_outputs(input string name);
        cmp({name, "_data"}, bus.o_data, 8'h00);
        cmp({name, "_load"}, bus.o_data_load, 0);
        cmp({name, "_busy"}, bus.o_busy, 0);
        cmp({name, "_done"}, bus.o_done, 0);
        cmp({name, "_ready"}, bus.o_ready, 0);
    endtask

    initial begin
        int acc;
        int nd;
        bus.i_valid   = 1'b0;
        bus.i_osc_sel = 1'b0;
        bus.i_param   = 2'd0;
        bus.i_value   = 24'd0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        cmp("ready_after_reset", bus.o_ready, 1);
        cmp("load_after_reset", bus.o_data_load, 0);
        cmp("data_after_reset", bus.o_data, 8'h00);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset_outputs("idle_async_reset");
        @(posedge clk);
        #2 rst = 1'b0;

        // osc1 wave 0x000002
        cap_bytes.delete();
        nd = done_cyc.size() + 1;
        start(1'b0, 2'd0, 24'h000002, acc);
        wait_done(nd);
        cmp("wave_done_cycle", done_cyc[nd-1] - acc, 31);
        cmp("wave_byte_period", cap_cyc[1] - cap_cyc[0], 10);
        check_bytes("wave", '{8'h01, 8'h02, 8'hFF, 0, 0, 0, 0, 0}, 3);

        // osc1 freq 0xFFEEFF
        cap_bytes.delete();
        nd = done_cyc.size() + 1;
        start(1'b0, 2'd1, 24'hFFEEFF, acc);
        wait_done(nd);
        cmp("freq_done_cycle", done_cyc[nd-1] - acc, 51);
        check_bytes("freq1", '{8'h02, 8'hFF, 8'hEE, 8'hFF, 8'hFF, 0, 0, 0}, 5);

        // osc2 freq 0xABCDEF then osc1 amp 0x12EEFF
        cap_bytes.delete();
        nd = done_cyc.size() + 1;
        start(1'b1, 2'd1, 24'hABCDEF, acc);
        wait_done(nd);
        check_bytes("freq2", '{8'h12, 8'hEF, 8'hCD, 8'hAB, 8'hFF, 0, 0, 0}, 5);
        cap_bytes.delete();
        nd = done_cyc.size() + 1;
        start(1'b0, 2'd3, 24'h12EEFF, acc);
        wait_done(nd);
        cmp("amp_done_cycle", done_cyc[nd-1] - acc, 41);
        check_bytes("amp", '{8'h04, 8'hFF, 8'hEE, 8'hFF, 0, 0, 0, 0}, 4);

        // Back-to-back with valid held and value changed mid-frame
        cap_bytes.delete();
        cap_cyc.delete();
        nd = done_cyc.size() + 1;
        @(posedge clk);
        #2;
        bus.i_osc_sel = 1'b0;
        bus.i_param   = 2'd0;
        bus.i_value   = 24'h0000AA;
        bus.i_valid   = 1'b1;
        @(posedge clk);
        #2 bus.i_value = 24'h0000BB;
        wait_done(nd);
        @(posedge clk);
        #2;
        bus.i_valid = 1'b0;
        bus.i_value = 24'h0000CC;
        wait_done(nd + 1);
        repeat (20) @(negedge clk);
        #1;
        check_bytes("b2b", '{8'h01, 8'hAA, 8'hFF, 8'h01, 8'hBB, 8'hFF, 0, 0}, 6);
        if (cap_cyc.size() >= 4) cmp("b2b_restart", cap_cyc[3] - done_cyc[nd-1], 1);
        cmp("b2b_done_count", done_cyc.size(), nd + 1);

        // Reset during the second data byte of a freq frame
        cap_bytes.delete();
        start(1'b0, 2'd1, 24'h332211, acc);
        for (int i = 0; i < 200 && cap_bytes.size() < 3; i++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset_outputs("midframe_reset");
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (60) @(negedge clk);
        #1;
        check_bytes("truncated", '{8'h02, 8'h11, 8'h22, 0, 0, 0, 0, 0}, 3);

        // osc2 phase 0x1234 after the truncated frame
        cap_bytes.delete();
        nd = done_cyc.size() + 1;
        start(1'b1, 2'd2, 24'h001234, acc);
        wait_done(nd);
        cmp("phase_done_cycle", done_cyc[nd-1] - acc, 41);
        check_bytes("phase", '{8'h13, 8'h34, 8'h12, 8'hFF, 0, 0, 0, 0}, 4);

        repeat (5) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
